cpu_net_iface: RTL and testbench

CPU_NET_IFACE -- requirements
Module: cpu_net_iface

---
 rtl/cpu_net_iface.sv | 142 ++++++++++++++
 tb/tb_cpu_net_iface.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_net_iface.sv
// cpu_net_iface
// Network interface between a CPU and the local port of a 2-D mesh router.
//
// TX path: CPU words, with a destination (x,y), are packed into 64-bit flits
// {dst_x, dst_y, payload} and queued in a TX FIFO whose head drives flit_out.
// RX path: flits from the router are checked against this node's (MY_X,MY_Y).
// Matching flits have their payload queued in an RX FIFO for the CPU. Any
// other flit is dropped and counted in a saturating 8-bit counter.
//
// Ports
//   clk, rst                      clock; synchronous active-low reset
//   tx_valid/tx_ready             CPU word handshake
//   tx_data, tx_dst_x, tx_dst_y   CPU payload and destination
//   flit_out/_valid/_ready        flits towards the router
//   flit_in/_valid/_ready         flits from the router
//   rx_data/rx_valid/rx_ready     payloads delivered to the CPU
//   tx_level                      TX FIFO occupancy
//   drop_cnt                      misaddressed flits discarded (saturating)
module cpu_net_iface #(
  parameter logic [15:0] MY_X     = 16'h0001,
  parameter logic [15:0] MY_Y     = 16'h0001,
  parameter int          TX_DEPTH = 4,
  parameter int          RX_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid,
  output logic        tx_ready,
  input  logic [31:0] tx_data,
  input  logic [15:0] tx_dst_x,
  input  logic [15:0] tx_dst_y,
  output logic [63:0] flit_out,
  output logic        flit_out_valid,
  input  logic        flit_out_ready,
  input  logic [63:0] flit_in,
  input  logic        flit_in_valid,
  output logic        flit_in_ready,
  output logic [31:0] rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic [2:0]  tx_level,
  output logic [7:0]  drop_cnt
);

  localparam int TX_AW = $clog2(TX_DEPTH);
  localparam int RX_AW = $clog2(RX_DEPTH);
  localparam logic [TX_AW:0] TX_FULL_LVL = TX_DEPTH[TX_AW:0];
  localparam logic [RX_AW:0] RX_FULL_LVL = RX_DEPTH[RX_AW:0];

  logic [63:0]      tx_mem [TX_DEPTH];
  logic [TX_AW-1:0] tx_wr_ptr;
  logic [TX_AW-1:0] tx_rd_ptr;
  logic [TX_AW:0]   tx_count;

  logic [31:0]      rx_mem [RX_DEPTH];
  logic [RX_AW-1:0] rx_wr_ptr;
  logic [RX_AW-1:0] rx_rd_ptr;
  logic [RX_AW:0]   rx_count;

  logic tx_push;
  logic tx_pop;
  logic rx_accept;
  logic rx_match;
  logic rx_push;
  logic rx_pop;
  logic rx_drop;

  // Occupancy counters, not pointer comparison, decide full/empty, so a
  // full FIFO never looks empty. Every handshake output is also gated by
  // rst, so nothing looks ready or valid while reset is held.
  assign tx_ready       = rst && (tx_count != TX_FULL_LVL);
  assign flit_out_valid = rst && (tx_count != '0);
  assign flit_out       = flit_out_valid ? tx_mem[tx_rd_ptr] : 64'h0;
  assign tx_level       = rst ? 3'(tx_count) : 3'd0;

  assign flit_in_ready  = rst && (rx_count != RX_FULL_LVL);
  assign rx_valid       = rst && (rx_count != '0);
  assign rx_data        = rx_valid ? rx_mem[rx_rd_ptr] : 32'h0;

  assign tx_push   = tx_valid && tx_ready;
  assign tx_pop    = flit_out_valid && flit_out_ready;
  assign rx_accept = flit_in_valid && flit_in_ready;
  assign rx_match  = (flit_in[63:48] == MY_X) && (flit_in[47:32] == MY_Y);
  assign rx_push   = rx_accept && rx_match;
  assign rx_drop   = rx_accept && !rx_match;
  assign rx_pop    = rx_valid && rx_ready;

  // TX FIFO: packs the CPU word at the tail. The head register is what the
  // router sees, so a new flit shows up one cycle after it is accepted.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tx_wr_ptr <= '0;
      tx_rd_ptr <= '0;
      tx_count  <= '0;
    end else begin
      if (tx_push) begin
        tx_mem[tx_wr_ptr] <= {tx_dst_x, tx_dst_y, tx_data};
        tx_wr_ptr         <= tx_wr_ptr + 1'b1;
      end
      if (tx_pop) begin
        tx_rd_ptr <= tx_rd_ptr + 1'b1;
      end
      case ({tx_push, tx_pop})
        2'b10:   tx_count <= tx_count + 1'b1;
        2'b01:   tx_count <= tx_count - 1'b1;
        default: tx_count <= tx_count;
      endcase
    end
  end

  // RX FIFO: only payloads addressed to this node are kept.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rx_wr_ptr <= '0;
      rx_rd_ptr <= '0;
      rx_count  <= '0;
    end else begin
      if (rx_push) begin
        rx_mem[rx_wr_ptr] <= flit_in[31:0];
        rx_wr_ptr         <= rx_wr_ptr + 1'b1;
      end
      if (rx_pop) begin
        rx_rd_ptr <= rx_rd_ptr + 1'b1;
      end
      case ({rx_push, rx_pop})
        2'b10:   rx_count <= rx_count + 1'b1;
        2'b01:   rx_count <= rx_count - 1'b1;
        default: rx_count <= rx_count;
      endcase
    end
  end

  // Misaddressed-flit counter sticks at 8'hFF instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      drop_cnt <= 8'h00;
    end else if (rx_drop && (drop_cnt != 8'hFF)) begin
      drop_cnt <= drop_cnt + 8'h01;
    end
  end

endmodule

// File: tb/tb_cpu_net_iface.sv
// tb_cpu_net_iface
// Self-checking bench for cpu_net_iface with MY=(1,1), TX_DEPTH=4,
// RX_DEPTH=2. It runs a directed vector table, hand-written multi-cycle
// sequences, and a randomized run against a queue-based reference model.
module tb_cpu_net_iface;

  localparam int TXD = 4;
  localparam int RXD = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        tx_valid;
  logic        tx_ready;
  logic [31:0] tx_data;
  logic [15:0] tx_dst_x;
  logic [15:0] tx_dst_y;
  logic [63:0] flit_out;
  logic        flit_out_valid;
  logic        flit_out_ready;
  logic [63:0] flit_in;
  logic        flit_in_valid;
  logic        flit_in_ready;
  logic [31:0] rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [2:0]  tx_level;
  logic [7:0]  drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain queues plus an unbounded drop tally.
  logic [63:0] m_tx_q[$];
  logic [31:0] m_rx_q[$];
  int          m_drop;

  always #5 clk = ~clk;

  cpu_net_iface #(
    .MY_X(16'h0001), .MY_Y(16'h0001), .TX_DEPTH(TXD), .RX_DEPTH(RXD)
  ) dut (
    .clk(clk), .rst(rst),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data),
    .tx_dst_x(tx_dst_x), .tx_dst_y(tx_dst_y),
    .flit_out(flit_out), .flit_out_valid(flit_out_valid),
    .flit_out_ready(flit_out_ready),
    .flit_in(flit_in), .flit_in_valid(flit_in_valid),
    .flit_in_ready(flit_in_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .tx_level(tx_level), .drop_cnt(drop_cnt)
  );

  typedef struct {
    logic        rst;
    logic        tx_valid;
    logic [31:0] tx_data;
    logic [15:0] dx;
    logic [15:0] dy;
    logic        fo_ready;
    logic [63:0] fin;
    logic        fin_valid;
    logic        rx_ready;
    logic        e_tx_ready;
    logic        e_fov;
    logic [63:0] e_fo;
    logic [2:0]  e_lvl;
    logic        e_fir;
    logic        e_rv;
    logic [31:0] e_rd;
    logic [7:0]  e_drop;
  } vec_t;

  vec_t vecs[12];

  task automatic check_output(input string name, input logic [63:0] act,
                              input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    rst            = v.rst;
    tx_valid       = v.tx_valid;
    tx_data        = v.tx_data;
    tx_dst_x       = v.dx;
    tx_dst_y       = v.dy;
    flit_out_ready = v.fo_ready;
    flit_in        = v.fin;
    flit_in_valid  = v.fin_valid;
    rx_ready       = v.rx_ready;
  endtask

  task automatic reset_dut();
    rst = 1'b0; tx_valid = 1'b0; tx_data = '0; tx_dst_x = '0; tx_dst_y = '0;
    flit_out_ready = 1'b0; flit_in = '0; flit_in_valid = 1'b0; rx_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    m_tx_q.delete();
    m_rx_q.delete();
    m_drop = 0;
  endtask

  task automatic compare_model(input string tag);
    logic        r;
    logic [63:0] e_fo;
    logic [31:0] e_rd;
    r    = rst;
    e_fo = (r && m_tx_q.size() > 0) ? m_tx_q[0] : 64'h0;
    e_rd = (r && m_rx_q.size() > 0) ? m_rx_q[0] : 32'h0;
    check_output({tag, "_tx_ready"}, 64'(tx_ready), 64'(r && m_tx_q.size() < TXD));
    check_output({tag, "_fo_valid"}, 64'(flit_out_valid), 64'(r && m_tx_q.size() > 0));
    check_output({tag, "_flit_out"}, flit_out, e_fo);
    check_output({tag, "_tx_level"}, 64'(tx_level), r ? 64'(m_tx_q.size()) : 64'h0);
    check_output({tag, "_fi_ready"}, 64'(flit_in_ready), 64'(r && m_rx_q.size() < RXD));
    check_output({tag, "_rx_valid"}, 64'(rx_valid), 64'(r && m_rx_q.size() > 0));
    check_output({tag, "_rx_data"}, 64'(rx_data), 64'(e_rd));
    check_output({tag, "_drop_cnt"}, 64'(drop_cnt), (m_drop > 255) ? 64'd255 : 64'(m_drop));
  endtask

  initial begin
    int   got;
    logic accepted;
    logic saw;

    // Directed table, starting with a reset cycle, then single send, RX
    // match, three kinds of misaddressed flit, and a self-addressed TX word
    // that must still go out on flit_out while a matching RX flit arrives.
    vecs[0]  = '{1'b0, 1'b0, 32'h0, 16'h0, 16'h0, 1'b0, 64'h0, 1'b0, 1'b0,
                 1'b0, 1'b0, 64'h0, 3'd0, 1'b0, 1'b0, 32'h0, 8'd0};
    vecs[1]  = '{1'b1, 1'b1, 32'h5, 16'h3, 16'h1, 1'b1, 64'h0, 1'b0, 1'b0,
                 1'b1, 1'b0, 64'h0, 3'd0, 1'b1, 1'b0, 32'h0, 8'd0};
    vecs[2]  = '{1'b1, 1'b0, 32'h0, 16'h0, 16'h0, 1'b1, 64'h0, 1'b0, 1'b0,
                 1'b1, 1'b1, 64'h0003_0001_0000_0005, 3'd1, 1'b1, 1'b0, 32'h0, 8'd0};
    vecs[3]  = '{1'b1, 1'b0, 32'h0, 16'h0, 16'h0, 1'b1, 64'h0001_0001_FFFF_FFFE, 1'b1, 1'b1,
                 1'b1, 1'b0, 64'h0, 3'd0, 1'b1, 1'b0, 32'h0, 8'd0};
    vecs[4]  = '{1'b1, 1'b0, 32'h0, 16'h0, 16'h0, 1'b1, 64'h0, 1'b0, 1'b1,
                 1'b1, 1'b0, 64'h0, 3'd0, 1'b1, 1'b1, 32'hFFFF_FFFE, 8'd0};
    vecs[5]  = '{1'b1, 1'b0, 32'h0, 16'h0, 16'h0, 1'b1, 64'h0002_0002_0000_1234, 1'b1, 1'b1,
                 1'b1, 1'b0, 64'h0, 3'd0, 1'b1, 1'b0, 32'h0, 8'd0};
    vecs[6]  = '{1'b1, 1'b0, 32'h0, 16'h0, 16'h0, 1'b1, 64'h0001_0002_0000_5678, 1'b1, 1'b1,
                 1'b1, 1'b0, 64'h0, 3'd0, 1'b1, 1'b0, 32'h0, 8'd1};
    vecs[7]  = '{1'b1, 1'b0, 32'h0, 16'h0, 16'h0, 1'b1, 64'h0002_0001_0000_9ABC, 1'b1, 1'b1,
                 1'b1, 1'b0, 64'h0, 3'd0, 1'b1, 1'b0, 32'h0, 8'd2};
    vecs[8]  = '{1'b1, 1'b1, 32'hDEAD_BEEF, 16'h1, 16'h1, 1'b0, 64'h0001_0001_8000_0000, 1'b1, 1'b1,
                 1'b1, 1'b0, 64'h0, 3'd0, 1'b1, 1'b0, 32'h0, 8'd3};
    vecs[9]  = '{1'b1, 1'b0, 32'h0, 16'h0, 16'h0, 1'b0, 64'h0, 1'b0, 1'b0,
                 1'b1, 1'b1, 64'h0001_0001_DEAD_BEEF, 3'd1, 1'b1, 1'b1, 32'h8000_0000, 8'd3};
    vecs[10] = '{1'b1, 1'b0, 32'h0, 16'h0, 16'h0, 1'b1, 64'h0, 1'b0, 1'b1,
                 1'b1, 1'b1, 64'h0001_0001_DEAD_BEEF, 3'd1, 1'b1, 1'b1, 32'h8000_0000, 8'd3};
    vecs[11] = '{1'b1, 1'b0, 32'h0, 16'h0, 16'h0, 1'b0, 64'h0, 1'b0, 1'b0,
                 1'b1, 1'b0, 64'h0, 3'd0, 1'b1, 1'b0, 32'h0, 8'd3};

    reset_dut();
    for (int i = 0; i < 12; i++) begin
      apply_stimulus(vecs[i]);
      @(negedge clk);
      check_output($sformatf("v%0d_tx_ready", i), 64'(tx_ready), 64'(vecs[i].e_tx_ready));
      check_output($sformatf("v%0d_fo_valid", i), 64'(flit_out_valid), 64'(vecs[i].e_fov));
      check_output($sformatf("v%0d_flit_out", i), flit_out, vecs[i].e_fo);
      check_output($sformatf("v%0d_tx_level", i), 64'(tx_level), 64'(vecs[i].e_lvl));
      check_output($sformatf("v%0d_fi_ready", i), 64'(flit_in_ready), 64'(vecs[i].e_fir));
      check_output($sformatf("v%0d_rx_valid", i), 64'(rx_valid), 64'(vecs[i].e_rv));
      check_output($sformatf("v%0d_rx_data", i), 64'(rx_data), 64'(vecs[i].e_rd));
      check_output($sformatf("v%0d_drop_cnt", i), 64'(drop_cnt), 64'(vecs[i].e_drop));
      @(posedge clk); #1;
    end

    // TX backpressure: four words fill the FIFO, the fifth is held until
    // space opens, and all five leave in push order.
    reset_dut();
    for (int i = 0; i < 4; i++) begin
      tx_valid = 1'b1; tx_data = 32'h100 + 32'(i); tx_dst_x = 16'h2; tx_dst_y = 16'h3;
      @(negedge clk);
      check_output($sformatf("bp_accept%0d", i), 64'(tx_ready), 64'd1);
      @(posedge clk); #1;
    end
    tx_data = 32'h104;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_output($sformatf("bp_full_ready%0d", i), 64'(tx_ready), 64'd0);
      if (i == 0) begin
        check_output("bp_full_level", 64'(tx_level), 64'd4);
        check_output("bp_full_head", flit_out, {16'h2, 16'h3, 32'h100});
      end
      @(posedge clk); #1;
    end
    flit_out_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 5; c++) begin
      @(negedge clk);
      if (flit_out_valid) begin
        check_output($sformatf("bp_flit%0d", got), flit_out, {16'h2, 16'h3, 32'h100 + 32'(got)});
        if (got < 2) check_output($sformatf("bp_drain_ready%0d", got), 64'(tx_ready), 64'(got == 1));
        got++;
      end
      accepted = tx_valid && tx_ready;
      @(posedge clk); #1;
      if (accepted) tx_valid = 1'b0;
    end
    check_output("bp_flit_count", 64'(got), 64'd5);
    @(negedge clk);
    check_output("bp_end_valid", 64'(flit_out_valid), 64'd0);
    check_output("bp_end_level", 64'(tx_level), 64'd0);
    check_output("bp_end_ready", 64'(tx_ready), 64'd1);
    @(posedge clk); #1;

    // Misaddressed stream: 300 flits to (2,2), drop counter saturates.
    reset_dut();
    rx_ready = 1'b1; flit_in_valid = 1'b1; saw = 1'b0;
    for (int i = 0; i < 300; i++) begin
      flit_in = {16'h2, 16'h2, 32'($urandom)};
      @(negedge clk);
      if (rx_valid) saw = 1'b1;
      if (i == 254) check_output("mis_drop_254", 64'(drop_cnt), 64'hFE);
      if (i == 255) check_output("mis_drop_255", 64'(drop_cnt), 64'hFF);
      @(posedge clk); #1;
    end
    flit_in_valid = 1'b0;
    @(negedge clk);
    check_output("mis_drop_sat", 64'(drop_cnt), 64'hFF);
    check_output("mis_rx_valid_seen", 64'(saw), 64'd0);
    @(posedge clk); #1;

    // RX full: third matching flit is held until the CPU drains.
    reset_dut();
    flit_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      flit_in = {16'h1, 16'h1, 32'(i + 1)};
      @(negedge clk);
      check_output($sformatf("rxf_ready%0d", i), 64'(flit_in_ready), 64'(i < 2));
      @(posedge clk); #1;
    end
    @(negedge clk);
    check_output("rxf_hold_ready", 64'(flit_in_ready), 64'd0);
    check_output("rxf_head", 64'(rx_data), 64'd1);
    @(posedge clk); #1;
    rx_ready = 1'b1;
    got = 0;
    for (int c = 0; c < 20 && got < 3; c++) begin
      @(negedge clk);
      if (rx_valid) begin
        check_output($sformatf("rxf_data%0d", got), 64'(rx_data), 64'(got + 1));
        got++;
      end
      accepted = flit_in_valid && flit_in_ready;
      @(posedge clk); #1;
      if (accepted) flit_in_valid = 1'b0;
    end
    check_output("rxf_count", 64'(got), 64'd3);

    // Reset mid-stream with three TX flits and one RX payload buffered.
    reset_dut();
    flit_in = {16'h1, 16'h1, 32'h77}; flit_in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tx_valid = 1'b1; tx_data = 32'hA0 + 32'(i); tx_dst_x = 16'h3; tx_dst_y = 16'h3;
      @(posedge clk); #1;
      flit_in_valid = 1'b0;
    end
    tx_valid = 1'b0;
    @(negedge clk);
    check_output("mid_level3", 64'(tx_level), 64'd3);
    check_output("mid_rx_valid", 64'(rx_valid), 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check_output("mid_rst_tx_ready", 64'(tx_ready), 64'd0);
    check_output("mid_rst_fo_valid", 64'(flit_out_valid), 64'd0);
    check_output("mid_rst_flit_out", flit_out, 64'h0);
    check_output("mid_rst_fi_ready", 64'(flit_in_ready), 64'd0);
    check_output("mid_rst_rx_valid", 64'(rx_valid), 64'd0);
    check_output("mid_rst_rx_data", 64'(rx_data), 64'h0);
    check_output("mid_rst_level", 64'(tx_level), 64'd0);
    @(posedge clk); #1;
    rst = 1'b1; flit_out_ready = 1'b1; rx_ready = 1'b1;
    saw = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (flit_out_valid || rx_valid) saw = 1'b1;
      if (i == 0) begin
        check_output("mid_rel_tx_ready", 64'(tx_ready), 64'd1);
        check_output("mid_rel_level", 64'(tx_level), 64'd0);
      end
      @(posedge clk); #1;
    end
    check_output("mid_stale_seen", 64'(saw), 64'd0);

    // Randomized run against the queue model, with occasional resets.
    reset_dut();
    for (int c = 0; c < 3000; c++) begin
      logic r, do_tx_push, do_tx_pop, do_rx_acc, do_rx_pop;
      @(negedge clk);
      compare_model("rnd");
      r          = rst;
      do_tx_push = r && tx_valid && (m_tx_q.size() < TXD);
      do_tx_pop  = r && flit_out_ready && (m_tx_q.size() > 0);
      do_rx_acc  = r && flit_in_valid && (m_rx_q.size() < RXD);
      do_rx_pop  = r && rx_ready && (m_rx_q.size() > 0);
      @(posedge clk); #1;
      if (!r) begin
        m_tx_q.delete();
        m_rx_q.delete();
        m_drop = 0;
      end else begin
        if (do_tx_pop) void'(m_tx_q.pop_front());
        if (do_tx_push) m_tx_q.push_back({tx_dst_x, tx_dst_y, tx_data});
        if (do_rx_pop) void'(m_rx_q.pop_front());
        if (do_rx_acc) begin
          if (flit_in[63:48] == 16'h1 && flit_in[47:32] == 16'h1)
            m_rx_q.push_back(flit_in[31:0]);
          else
            m_drop++;
        end
      end
      if (!tx_valid || do_tx_push || !r) begin
        tx_valid = ($urandom_range(0, 1) == 1);
        tx_data  = $urandom;
        tx_dst_x = 16'($urandom_range(0, 3));
        tx_dst_y = 16'($urandom_range(0, 3));
      end
      if (!flit_in_valid || do_rx_acc || !r) begin
        flit_in_valid = ($urandom_range(0, 1) == 1);
        if ($urandom_range(0, 1) == 1)
          flit_in = {16'h1, 16'h1, 32'($urandom)};
        else
          flit_in = {16'($urandom_range(0, 3)), 16'($urandom_range(0, 3)), 32'($urandom)};
      end
      flit_out_ready = ($urandom_range(0, 9) < 7);
      rx_ready       = ($urandom_range(0, 9) < 6);
      rst            = ($urandom_range(0, 99) != 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
